// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: 1-cycle registered fetch port plus a
// byte-serial program loader that holds fetch off while it runs.
//
// Ports:
//   clk, rstn                 clock, async active-low reset
//   i_pc -> o_inst, o_addr    fetch byte address -> {instruction, address}
//   i_ld_start/base/len       load request (sampled in IDLE only)
//   i_ld_byte/valid, o_ld_ready   little-endian byte stream handshake
//   o_ld_busy, o_ld_done, o_ld_err   loader status
`ifndef INIT_PC
`define INIT_PC 32'h8000_0000
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif
`ifndef INVALID_PC
`define INVALID_PC 32'hFFFF_FFFF
`endif

module inst_mem_responder #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned ILEN        = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [XLEN-1:0] BASE_ADDR = `INIT_PC
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [XLEN-1:0] i_pc,
   output logic [ILEN-1:0] o_inst,
   output logic [XLEN-1:0] o_addr,
   input  logic            i_ld_start,
   input  logic [XLEN-1:0] i_ld_base,
   input  logic [15:0]     i_ld_len,
   input  logic [7:0]      i_ld_byte,
   input  logic            i_ld_valid,
   output logic            o_ld_ready,
   output logic            o_ld_busy,
   output logic            o_ld_done,
   output logic            o_ld_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [XLEN:0] DEPTH_X = (XLEN+1)'(DEPTH_WORDS);
   localparam logic [XLEN:0] END_X = {1'b0, BASE_ADDR} + (DEPTH_X << 2);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   state_t          state, state_n;
   logic [AW-1:0]   ptr, ptr_n;
   logic [15:0]     cnt, cnt_n;
   logic [1:0]      bc, bc_n;
   logic [ILEN-1:0] word, word_n;
   logic            ld_err, err_n;
   logic            mem_we;
   logic [ILEN-1:0] inst_q;
   logic [XLEN-1:0] addr_q;

   logic [ILEN-1:0] mem [DEPTH_WORDS];

   // fetch decode
   logic            pc_ok;
   logic [AW-1:0]   f_idx;

   assign pc_ok = (i_pc[1:0] == 2'b00) &&
                  (i_pc >= BASE_ADDR) &&
                  ({1'b0, i_pc} < END_X);
   assign f_idx = AW'((i_pc - BASE_ADDR) >> 2);

   // load request check; the sum is XLEN+1 bits so it cannot wrap
   logic            ld_bad;
   logic [AW-1:0]   ld_idx;
   logic [XLEN:0]   ld_end;

   assign ld_idx = AW'((i_ld_base - BASE_ADDR) >> 2);
   assign ld_end = {1'b0, (i_ld_base - BASE_ADDR) >> 2} +
                   (XLEN+1)'(i_ld_len);
   assign ld_bad = (i_ld_base[1:0] != 2'b00) ||
                   (i_ld_base < BASE_ADDR) ||
                   (ld_end > DEPTH_X);

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      cnt_n   = cnt;
      bc_n    = bc;
      word_n  = word;
      err_n   = ld_err;
      mem_we  = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_ld_start) begin
               if (ld_bad) begin
                  err_n   = 1'b1;
                  state_n = DONE;
               end else if (i_ld_len == 16'd0) begin
                  err_n   = 1'b0;
                  state_n = DONE;
               end else begin
                  err_n   = 1'b0;
                  ptr_n   = ld_idx;
                  cnt_n   = i_ld_len;
                  bc_n    = 2'd0;
                  state_n = RECV;
               end
            end
         end
         RECV: begin
            if (i_ld_valid) begin
               word_n[{bc, 3'b000} +: 8] = i_ld_byte;
               bc_n = bc + 2'd1;
               if (bc == 2'd3) state_n = WRITE;
            end
         end
         WRITE: begin
            mem_we = 1'b1;
            ptr_n  = ptr + 1'b1;
            cnt_n  = cnt - 16'd1;
            if (cnt == 16'd1) begin
               state_n = DONE;
            end else begin
               bc_n    = 2'd0;
               state_n = RECV;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         ptr    <= '0;
         cnt    <= '0;
         bc     <= '0;
         word   <= '0;
         ld_err <= 1'b0;
      end else begin
         state  <= state_n;
         ptr    <= ptr_n;
         cnt    <= cnt_n;
         bc     <= bc_n;
         word   <= word_n;
         ld_err <= err_n;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[ptr] <= word;
   end

   // fetch is only served while the loader is idle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inst_q <= `NOP;
         addr_q <= `INVALID_PC;
      end else if (state == IDLE && pc_ok) begin
         inst_q <= mem[f_idx];
         addr_q <= i_pc;
      end else begin
         inst_q <= `NOP;
         addr_q <= `INVALID_PC;
      end
   end

   assign o_inst     = inst_q;
   assign o_addr     = addr_q;
   assign o_ld_ready = (state == RECV);
   assign o_ld_busy  = (state != IDLE);
   assign o_ld_done  = (state == DONE);
   assign o_ld_err   = ld_err;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: loader, fetch window,
// rejection cases, fetch hold-off and reset during a load.
module tb_inst_mem_responder;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 16;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] INV   = 32'hFFFF_FFFF;

   logic        clk = 0;
   logic        rstn = 0;
   logic [31:0] i_pc = BASE;
   logic [31:0] o_inst, o_addr;
   logic        i_ld_start = 0;
   logic [31:0] i_ld_base = '0;
   logic [15:0] i_ld_len = '0;
   logic [7:0]  i_ld_byte = '0;
   logic        i_ld_valid = 0;
   logic        o_ld_ready, o_ld_busy, o_ld_done, o_ld_err;

   int nvec = 0;
   int nerr = 0;
   logic [7:0] lb[$];

   always #5 clk = ~clk;

   inst_mem_responder #(
      .XLEN(32), .ILEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rstn(rstn), .i_pc(i_pc),
      .o_inst(o_inst), .o_addr(o_addr),
      .i_ld_start(i_ld_start), .i_ld_base(i_ld_base),
      .i_ld_len(i_ld_len), .i_ld_byte(i_ld_byte),
      .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
      .o_ld_busy(o_ld_busy), .o_ld_done(o_ld_done),
      .o_ld_err(o_ld_err)
   );

   task automatic do_fetch(input logic [31:0] pc);
      @(negedge clk);
      i_pc = pc;
      @(negedge clk);
   endtask

   // drives one load from lb; gap=1 offers a byte only every other cycle
   // and pushes junk with valid while the loader is not ready
   task automatic run_load(input logic [31:0] base, input logic [15:0] len,
                           input bit gap, output int dones,
                           output bit saw_rdy, output int bad_addr,
                           output bit tmo);
      int k;
      bit prev_busy;
      bit fin;
      dones = 0; saw_rdy = 0; bad_addr = 0;
      k = 0; prev_busy = 0; fin = 0;
      @(negedge clk);
      i_ld_base = base; i_ld_len = len; i_ld_start = 1;
      @(negedge clk);
      i_ld_start = 0;
      for (int c = 0; c < 300 && !fin; c++) begin
         if (o_ld_ready) saw_rdy = 1;
         if (prev_busy && o_addr !== INV) bad_addr++;
         if (o_ld_done) begin
            dones++;
            fin = 1;
            i_ld_valid = 0;
         end else if (o_ld_ready && k < lb.size() &&
                      (!gap || c % 2 == 0)) begin
            i_ld_byte = lb[k];
            i_ld_valid = 1;
            k++;
         end else begin
            i_ld_byte = 8'hFF;
            i_ld_valid = gap && !o_ld_ready;
         end
         prev_busy = o_ld_busy;
         @(negedge clk);
      end
      tmo = !fin;
      if (o_ld_done) dones++;
      if (prev_busy && o_addr !== INV) bad_addr++;
   endtask

   task automatic test_reset;
      rstn = 0;
      i_pc = BASE;
      repeat (2) @(negedge clk);
      nvec++; if (o_inst !== NOP) begin nerr++;
         $display("FAIL reset_inst got %h want %h", o_inst, NOP); end
      nvec++; if (o_addr !== INV) begin nerr++;
         $display("FAIL reset_addr got %h want %h", o_addr, INV); end
      nvec++; if ({o_ld_ready, o_ld_busy, o_ld_done, o_ld_err} !== 4'b0) begin
         nerr++; $display("FAIL reset_flags got %b want 0000",
            {o_ld_ready, o_ld_busy, o_ld_done, o_ld_err}); end
      rstn = 1;
      @(negedge clk);
   endtask

   task automatic test_load_basic;
      int d, bad; bit rdy, tmo;
      lb = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load(BASE, 16'd2, 0, d, rdy, bad, tmo);
      nvec++; if (tmo !== 0 || d !== 1) begin nerr++;
         $display("FAIL basic_done got %0d pulses tmo %0d want 1 0", d, tmo); end
      nvec++; if (o_ld_err !== 0) begin nerr++;
         $display("FAIL basic_err got %b want 0", o_ld_err); end
      do_fetch(BASE);
      nvec++; if (o_inst !== 32'h0000_0013 || o_addr !== BASE) begin nerr++;
         $display("FAIL fetch_w0 got %h@%h want 00000013@%h", o_inst, o_addr, BASE); end
      do_fetch(BASE + 4);
      nvec++; if (o_inst !== 32'h0010_0093 || o_addr !== BASE + 4) begin nerr++;
         $display("FAIL fetch_w1 got %h@%h want 00100093@%h", o_inst, o_addr, BASE + 4); end
   endtask

   task automatic test_fetch_bounds;
      do_fetch(BASE + 2);
      nvec++; if (o_inst !== NOP || o_addr !== INV) begin nerr++;
         $display("FAIL fetch_misal got %h@%h want %h@%h", o_inst, o_addr, NOP, INV); end
      do_fetch(BASE + 4 * DEPTH);
      nvec++; if (o_inst !== NOP || o_addr !== INV) begin nerr++;
         $display("FAIL fetch_top got %h@%h want %h@%h", o_inst, o_addr, NOP, INV); end
      do_fetch(BASE - 4);
      nvec++; if (o_inst !== NOP || o_addr !== INV) begin nerr++;
         $display("FAIL fetch_below got %h@%h want %h@%h", o_inst, o_addr, NOP, INV); end
   endtask

   task automatic test_reject;
      int d, bad; bit rdy, tmo;
      logic [31:0] last;
      last = BASE + 4 * (DEPTH - 1);
      lb = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_load(last, 16'd1, 0, d, rdy, bad, tmo);
      nvec++; if (o_ld_err !== 0 || d !== 1) begin nerr++;
         $display("FAIL fit_load got err %b pulses %0d want 0 1", o_ld_err, d); end
      run_load(last, 16'd2, 0, d, rdy, bad, tmo);
      nvec++; if (o_ld_err !== 1 || d !== 1 || rdy !== 0) begin nerr++;
         $display("FAIL overrun got err %b pulses %0d rdy %b want 1 1 0",
            o_ld_err, d, rdy); end
      do_fetch(last);
      nvec++; if (o_inst !== 32'h4433_2211 || o_addr !== last) begin nerr++;
         $display("FAIL last_word got %h@%h want 44332211@%h", o_inst, o_addr, last); end
      run_load(BASE, 16'd0, 0, d, rdy, bad, tmo);
      nvec++; if (o_ld_err !== 0 || d !== 1 || rdy !== 0) begin nerr++;
         $display("FAIL len0 got err %b pulses %0d rdy %b want 0 1 0",
            o_ld_err, d, rdy); end
      run_load(BASE + 2, 16'd1, 0, d, rdy, bad, tmo);
      nvec++; if (o_ld_err !== 1 || d !== 1 || rdy !== 0) begin nerr++;
         $display("FAIL base_misal got err %b pulses %0d rdy %b want 1 1 0",
            o_ld_err, d, rdy); end
      run_load(BASE - 4, 16'd1, 0, d, rdy, bad, tmo);
      nvec++; if (o_ld_err !== 1 || d !== 1 || rdy !== 0) begin nerr++;
         $display("FAIL base_below got err %b pulses %0d rdy %b want 1 1 0",
            o_ld_err, d, rdy); end
   endtask

   task automatic test_gapped_load;
      int d, bad; bit rdy, tmo;
      i_pc = BASE;
      lb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_load(BASE + 8, 16'd1, 1, d, rdy, bad, tmo);
      nvec++; if (tmo !== 0 || d !== 1 || o_ld_err !== 0) begin nerr++;
         $display("FAIL gap_done got pulses %0d tmo %0d err %b want 1 0 0",
            d, tmo, o_ld_err); end
      nvec++; if (bad !== 0) begin nerr++;
         $display("FAIL gap_holdoff got %0d valid addrs while busy want 0", bad); end
      do_fetch(BASE);
      nvec++; if (o_inst !== 32'h0000_0013 || o_addr !== BASE) begin nerr++;
         $display("FAIL gap_resume got %h@%h want 00000013@%h", o_inst, o_addr, BASE); end
      do_fetch(BASE + 8);
      nvec++; if (o_inst !== 32'hDEAD_BEEF || o_addr !== BASE + 8) begin nerr++;
         $display("FAIL gap_word got %h@%h want deadbeef@%h", o_inst, o_addr, BASE + 8); end
   endtask

   task automatic test_reset_mid_load;
      int d, bad; bit rdy, tmo;
      @(negedge clk);
      i_ld_base = BASE + 12; i_ld_len = 16'd1; i_ld_start = 1;
      @(negedge clk);
      i_ld_start = 0;
      i_ld_byte = 8'h55; i_ld_valid = 1;
      @(negedge clk);
      i_ld_byte = 8'h66;
      @(negedge clk);
      i_ld_valid = 0;
      #2 rstn = 0;
      #1;
      nvec++; if ({o_ld_ready, o_ld_busy, o_ld_done, o_ld_err} !== 4'b0) begin
         nerr++; $display("FAIL midrst_flags got %b want 0000",
            {o_ld_ready, o_ld_busy, o_ld_done, o_ld_err}); end
      nvec++; if (o_inst !== NOP || o_addr !== INV) begin nerr++;
         $display("FAIL midrst_fetch got %h@%h want %h@%h", o_inst, o_addr, NOP, INV); end
      @(negedge clk);
      rstn = 1;
      do_fetch(BASE + 4);
      nvec++; if (o_inst !== 32'h0010_0093 || o_addr !== BASE + 4) begin nerr++;
         $display("FAIL midrst_keep got %h@%h want 00100093@%h", o_inst, o_addr, BASE + 4); end
      lb = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_load(BASE + 12, 16'd1, 0, d, rdy, bad, tmo);
      nvec++; if (tmo !== 0 || d !== 1 || o_ld_err !== 0 || rdy !== 1) begin nerr++;
         $display("FAIL midrst_reload got pulses %0d tmo %0d err %b rdy %b want 1 0 0 1",
            d, tmo, o_ld_err, rdy); end
      do_fetch(BASE + 12);
      nvec++; if (o_inst !== 32'h0403_0201 || o_addr !== BASE + 12) begin nerr++;
         $display("FAIL midrst_word got %h@%h want 04030201@%h", o_inst, o_addr, BASE + 12); end
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_fetch_bounds();
      test_reject();
      test_gapped_load();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
